// File: rtl/des_pkg.sv
// Shared DES datapath constants, S-box edit payload and loader state encoding.
package des_pkg;

  localparam int unsigned NUM_SBOX = 8;
  localparam int unsigned NUM_ROWS = 4;
  localparam int unsigned NUM_COLS = 16;
  localparam int unsigned VAL_W    = 4;

  localparam int unsigned SBOX_W = $clog2(NUM_SBOX);
  localparam int unsigned ROW_W  = $clog2(NUM_ROWS);
  localparam int unsigned COL_W  = $clog2(NUM_COLS);

  localparam int unsigned ENTRIES_PER_SBOX = NUM_ROWS * NUM_COLS;

  // One write on the S-box edit port
  typedef struct packed {
    logic [SBOX_W-1:0] sbox;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
    logic [VAL_W-1:0]  val;
  } sbox_edit_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } loader_state_e;

endpackage

// File: rtl/sbox_addr_counter.sv
// Three-level S-box / row / column address counter, column fastest.
module sbox_addr_counter
  import des_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic [SBOX_W-1:0] start_sbox,
  input  logic              load_all,
  input  logic              advance,
  output logic [SBOX_W-1:0] sbox,
  output logic [ROW_W-1:0]  row,
  output logic [COL_W-1:0]  col,
  output logic              last_c
);

  logic [SBOX_W-1:0] sbox_q, sbox_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic              col_wrap_c;
  logic              row_wrap_c;
  logic              sbox_wrap_c;

  assign col_wrap_c  = (col_q == COL_W'(NUM_COLS - 1));
  assign row_wrap_c  = (row_q == ROW_W'(NUM_ROWS - 1));
  assign sbox_wrap_c = (sbox_q == SBOX_W'(NUM_SBOX - 1));

  // Final entry: end of the last row; in load_all mode also the last S-box
  assign last_c = col_wrap_c && row_wrap_c && (!load_all || sbox_wrap_c);

  // Next address: clear loads the starting S-box, advance steps col/row/sbox
  always_comb begin
    sbox_d = sbox_q;
    row_d  = row_q;
    col_d  = col_q;
    if (clear) begin
      sbox_d = start_sbox;
      row_d  = '0;
      col_d  = '0;
    end else if (advance) begin
      if (col_wrap_c) begin
        col_d = '0;
        if (row_wrap_c) begin
          row_d = '0;
          if (load_all && !sbox_wrap_c) begin
            sbox_d = sbox_q + SBOX_W'(1);
          end
        end else begin
          row_d = row_q + ROW_W'(1);
        end
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  // Address registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sbox_q <= '0;
      row_q  <= '0;
      col_q  <= '0;
    end else begin
      sbox_q <= sbox_d;
      row_q  <= row_d;
      col_q  <= col_d;
    end
  end

  assign sbox = sbox_q;
  assign row  = row_q;
  assign col  = col_q;

endmodule

// File: rtl/sbox_table_loader.sv
// Turns a valid/ready nibble stream into the S-box array edit-port write sequence.
module sbox_table_loader
  import des_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              load_all,
  input  logic [SBOX_W-1:0] target_sbox,
  input  logic              abort,
  input  logic              s_valid,
  input  logic [VAL_W-1:0]  s_data,
  output logic              s_ready,
  output logic              edit_sbox,
  output logic [VAL_W-1:0]  new_sbox_val,
  output logic [SBOX_W-1:0] sbox_sel,
  output logic [ROW_W-1:0]  row_sel,
  output logic [COL_W-1:0]  col_sel,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

  loader_state_e state_q, state_d;
  logic          load_all_q, load_all_d;
  sbox_edit_t    edit_q, edit_d;
  logic          edit_sbox_q, edit_sbox_d;
  logic          s_ready_q, s_ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          aborted_q, aborted_d;

  logic              hs_c;
  logic              cnt_clear_c;
  logic              cnt_last_c;
  logic [SBOX_W-1:0] cnt_start_c;
  logic [SBOX_W-1:0] cnt_sbox;
  logic [ROW_W-1:0]  cnt_row;
  logic [COL_W-1:0]  cnt_col;

  assign cnt_start_c = load_all ? '0 : target_sbox;

  sbox_addr_counter u_addr (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (cnt_clear_c),
    .start_sbox (cnt_start_c),
    .load_all   (load_all_q),
    .advance    (hs_c),
    .sbox       (cnt_sbox),
    .row        (cnt_row),
    .col        (cnt_col),
    .last_c     (cnt_last_c)
  );

  // Next state, handshake decode and next values of every registered output
  always_comb begin
    state_d     = state_q;
    load_all_d  = load_all_q;
    edit_d      = edit_q;
    edit_sbox_d = 1'b0;
    done_d      = 1'b0;
    aborted_d   = 1'b0;
    hs_c        = 1'b0;
    cnt_clear_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d     = ST_LOAD;
          load_all_d  = load_all;
          cnt_clear_c = 1'b1;
        end
      end
      ST_LOAD: begin
        // A handshake coinciding with abort is dropped
        if (abort) begin
          state_d   = ST_IDLE;
          aborted_d = 1'b1;
        end else if (s_valid && s_ready_q) begin
          hs_c        = 1'b1;
          edit_sbox_d = 1'b1;
          edit_d.sbox = cnt_sbox;
          edit_d.row  = cnt_row;
          edit_d.col  = cnt_col;
          edit_d.val  = s_data;
          if (cnt_last_c) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    s_ready_d = (state_d == ST_LOAD);
    busy_d    = (state_d == ST_LOAD);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      load_all_q  <= 1'b0;
      edit_q      <= '0;
      edit_sbox_q <= 1'b0;
      s_ready_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_all_q  <= load_all_d;
      edit_q      <= edit_d;
      edit_sbox_q <= edit_sbox_d;
      s_ready_q   <= s_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
    end
  end

  assign s_ready      = s_ready_q;
  assign edit_sbox    = edit_sbox_q;
  assign new_sbox_val = edit_q.val;
  assign sbox_sel     = edit_q.sbox;
  assign row_sel      = edit_q.row;
  assign col_sel      = edit_q.col;
  assign busy         = busy_q;
  assign done         = done_q;
  assign aborted      = aborted_q;

endmodule
